// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch-side control of the MIPS core.
package cpu_pkg;

    // Default program-counter width in bits (byte address).
    localparam int PC_WIDTH = 7;

    // Default sequential fetch increment in bytes.
    localparam int PC_STEP = 4;

    // Program-counter value type.
    typedef logic [PC_WIDTH-1:0] pc_t;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

endpackage : cpu_pkg

// File: rtl/next_pc_sel.sv
// Next-PC selection: halt > jump > branch > sequential. A redirect whose
// target is not word aligned is dropped in favour of the sequential PC,
// and the drop is reported through misaligned.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_WIDTH,
    parameter int STEP = PC_STEP
) (
    input  logic [PC_W-1:0] pc,
    input  logic            halt,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] next_pc,
    output logic            misaligned
);

    localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

    logic [PC_W-1:0] pc_inc_s;

    // Sequential address wraps naturally at PC_W bits.
    assign pc_inc_s = pc + STEP_V;

    // Priority selection with alignment screening of redirect targets.
    always_comb begin
        next_pc    = pc_inc_s;
        misaligned = 1'b0;
        if (halt) begin
            next_pc = pc;
        end else if (jump) begin
            if (jump_target[1:0] != 2'b00) begin
                misaligned = 1'b1;
                next_pc    = pc_inc_s;
            end else begin
                next_pc = jump_target;
            end
        end else if (branch_taken) begin
            if (branch_target[1:0] != 2'b00) begin
                misaligned = 1'b1;
                next_pc    = pc_inc_s;
            end else begin
                next_pc = branch_target;
            end
        end else begin
            next_pc = pc_inc_s;
        end
    end

endmodule : next_pc_sel

// File: rtl/pc_sequencer.sv
// Fetch-side controller: owns the PC, issues instruction fetch requests
// and advances the PC when an instruction is accepted (req && ack).
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_WIDTH,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              STEP     = PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            imem_ack,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            halt,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc,
    output logic            instr_valid,
    output logic            halted,
    output logic            align_err
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            halted_q, halted_d;
    logic            align_err_q, align_err_d;

    logic            req_s;
    logic            accept_s;
    logic [PC_W-1:0] next_pc_s;
    logic            misaligned_s;

    next_pc_sel #(
        .PC_W (PC_W),
        .STEP (STEP)
    ) u_next_pc_sel (
        .pc            (pc_q),
        .halt          (halt),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc_s),
        .misaligned    (misaligned_s)
    );

    // Request is only raised while fetching and not stalled; ack without a
    // request never counts as an acceptance.
    assign req_s    = (state_q == FETCH) && !stall;
    assign accept_s = req_s && imem_ack;

    // Next-state and register update selection.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = 1'b0;
        align_err_d   = align_err_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (accept_s) begin
                    instr_valid_d = 1'b1;
                    pc_d          = next_pc_s;
                    if (misaligned_s) begin
                        align_err_d = 1'b1;
                    end else begin
                        align_err_d = align_err_q;
                    end
                    if (halt) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        halted_d = (state_d == HALTED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            align_err_q   <= align_err_d;
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign align_err   = align_err_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with an expectation queue.
module tb_pc_sequencer;

    localparam int PC_W = 7;

    typedef struct packed {
        logic            chk_req;
        logic            req;
        logic [PC_W-1:0] pc;
        logic            iv;
        logic            halted;
        logic            ae;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            imem_ack;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic            halt;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [PC_W-1:0] pc;
    logic            instr_valid;
    logic            halted;
    logic            align_err;

    int   vectors;
    int   miscompares;
    exp_t sb_q[$];

    pc_sequencer #(
        .PC_W     (PC_W),
        .RESET_PC (7'b0000000),
        .STEP     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .imem_ack      (imem_ack),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .align_err     (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs: push expectations, check the request in the
    // cycle, then check registered outputs just after the edge.
    task automatic step(input string tag,
                        input logic r, input logic st, input logic ack,
                        input logic br, input logic [PC_W-1:0] bt,
                        input logic j, input logic [PC_W-1:0] jt,
                        input logic h,
                        input logic chk_req, input logic e_req,
                        input logic [PC_W-1:0] e_pc, input logic e_iv,
                        input logic e_halted, input logic e_ae);
        exp_t e;
        rst           = r;
        stall         = st;
        imem_ack      = ack;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        halt          = h;
        sb_q.push_back('{chk_req: chk_req, req: e_req, pc: e_pc, iv: e_iv,
                         halted: e_halted, ae: e_ae});
        #1;
        e = sb_q.pop_front();
        if (e.chk_req) begin
            chk({tag, ".req"}, 32'(imem_req), 32'(e.req));
        end
        @(posedge clk);
        #1;
        chk({tag, ".pc"},     32'(pc),          32'(e.pc));
        chk({tag, ".addr"},   32'(imem_addr),   32'(e.pc));
        chk({tag, ".iv"},     32'(instr_valid), 32'(e.iv));
        chk({tag, ".halted"}, 32'(halted),      32'(e.halted));
        chk({tag, ".ae"},     32'(align_err),   32'(e.ae));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0; stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
        branch_target = 7'h00; jump = 1'b0; jump_target = 7'h00; halt = 1'b0;
        @(negedge clk);

        // Reset for two cycles with ack tied high, then boot.
        step("rst0",  1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        step("rst1",  1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        step("boot",  1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        step("seq4",  1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h04, 1'b1, 1'b0, 1'b0);
        step("seq8",  1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h08, 1'b1, 1'b0, 1'b0);

        // Stall holds the PC and drops the request even with ack high.
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 7'h40, 1'b0, 1'b1, 1'b0, 7'h08, 1'b0, 1'b0, 1'b0);
        end
        // No ack: request stays up, PC held, no instruction.
        for (int i = 0; i < 2; i++) begin
            step("noack", 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h08, 1'b0, 1'b0, 1'b0);
        end
        step("seq12", 1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h0C, 1'b1, 1'b0, 1'b0);

        // Redirects.
        step("branch",  1'b1, 1'b0, 1'b1, 1'b1, 7'h20, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h20, 1'b1, 1'b0, 1'b0);
        step("jmpwin",  1'b1, 1'b0, 1'b1, 1'b1, 7'h20, 1'b1, 7'h40, 1'b0, 1'b1, 1'b1, 7'h40, 1'b1, 1'b0, 1'b0);
        step("jmpnack", 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 7'h10, 1'b0, 1'b1, 1'b1, 7'h40, 1'b0, 1'b0, 1'b0);
        step("jmp7c",   1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 7'h7C, 1'b0, 1'b1, 1'b1, 7'h7C, 1'b1, 1'b0, 1'b0);

        // Wrap-around and misaligned redirect.
        step("wrap",    1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h00, 1'b1, 1'b0, 1'b0);
        step("misal",   1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 7'h41, 1'b0, 1'b1, 1'b1, 7'h04, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step("sticky", 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h04, 1'b0, 1'b0, 1'b1);
        end
        step("misbr",   1'b1, 1'b0, 1'b1, 1'b1, 7'h22, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h08, 1'b1, 1'b0, 1'b1);
        step("jmp10",   1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 7'h10, 1'b0, 1'b1, 1'b1, 7'h10, 1'b1, 1'b0, 1'b1);

        // Halt wins over a simultaneous jump, then everything is frozen.
        step("halt",    1'b1, 1'b0, 1'b1, 1'b1, 7'h20, 1'b1, 7'h40, 1'b1, 1'b1, 1'b1, 7'h10, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("frozen", 1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 7'h40, 1'b0, 1'b1, 1'b0, 7'h10, 1'b0, 1'b1, 1'b1);
        end
        step("hrst",    1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 7'h40, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        step("hboot",   1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        step("hseq4",   1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h04, 1'b1, 1'b0, 1'b0);

        // Reset in the same cycle as an accepted jump: reset wins, back to BOOT.
        step("midrst",  1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 7'h40, 1'b0, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
        step("mboot",   1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 7'h40, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        step("mseq4",   1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h04, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller for the single-cycle MIPS core: owns the program-counter value, issues instruction-memory fetch requests, and selects the next PC from reset vector, sequential increment, branch target or jump target. Sits between the decode/branch logic and instruction memory. Sequential fetch is gated by a req/ack handshake, stall and halt.

## Interface
- PC_W, 7, PC width in bits (byte address).
- RESET_PC, 7'b0000000, PC loaded on reset.
- STEP, 4, sequential increment in bytes.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- stall  in  1  hold the PC and suppress the request this cycle.
- imem_ack  in  1  instruction memory returns data for `imem_addr` this cycle.
- branch_taken  in  1  current instruction is a taken branch; qualified by `imem_ack`.
- branch_target  in  PC_W  branch destination.
- jump  in  1  current instruction is a jump; qualified by `imem_ack`.
- jump_target  in  PC_W  jump destination.
- halt  in  1  current instruction halts the core; qualified by `imem_ack`.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; equals `pc`.
- pc  out  PC_W  current registered PC.
- instr_valid  out  1  one-cycle pulse when an instruction was accepted (registered).
- halted  out  1  core is in HALTED.
- align_err  out  1  sticky flag: a misaligned redirect target was seen.

## Operation
- FSM states are BOOT, FETCH and HALTED.
- **Reset** (`rst`=0 at a rising edge):
  - state=BOOT, pc=RESET_PC.
  - instr_valid=0, halted=0, align_err=0.
- **BOOT**:
  - imem_req=0.
  - Moves to FETCH unconditionally on the next edge with `rst`=1.
- **FETCH**:
  - imem_req = !stall (combinational from state and stall).
  - imem_addr = pc.
  - An instruction is accepted when imem_req && imem_ack.
  - On acceptance, pc is updated at the edge with the first matching case below:
    - halt: pc holds; next state HALTED.
    - jump: pc = jump_target.
    - branch_taken: pc = branch_target.
    - Otherwise: pc = pc + STEP, truncated to PC_W bits (wrap-around).
  - When no instruction is accepted (stall=1 or imem_ack=0): pc holds, and jump/branch/halt are ignored.
- **HALTED**:
  - imem_req=0, halted=1, pc frozen.
  - Only reset exits this state.
- **Misaligned redirect**: the selected target has [1:0]≠0.
  - The redirect is discarded; pc = pc + STEP instead.
  - align_err is set and stays set until reset.
- **Simultaneous controls**: jump and branch_taken both high → jump wins. halt with anything → halt wins.
- **Reset mid-operation**: reset overrides all inputs in any state, including a pending ack.

## Timing
- Reset deasserted before edge E0 → BOOT during cycle after E0 → FETCH from E1.
- First imem_req is high in the cycle after E1 (unless stall).
- Accepting an instruction at edge E → the new pc is visible right after E; instr_valid=1 for exactly the cycle after E.
- Back-to-back: with ack held high and stall low, one instruction is accepted per cycle.
- imem_ack while imem_req=0 is ignored.
- All outputs except imem_req/imem_addr are registered.

## Structure
- Package `cpu_pkg` holds:
  - typedef `pc_t` (logic [PC_W-1:0]).
  - enum `seq_state_t` {BOOT, FETCH, HALTED}.
  - constant `PC_STEP`=4.
- One combinational sub-module `next_pc_sel` holds priority selection, alignment check and wrap-around add. Inputs: pc, the controls, the targets. Outputs: next_pc, misaligned.
- FSM and registers live in `pc_sequencer`.

## Test plan
- **Reset/boot:** rst=0 for 2 cycles, then 1, with ack tied high.
  - pc=0, imem_req=0 in BOOT.
  - req high the next cycle.
  - pc steps 0→4→8→12 on consecutive edges; instr_valid high each cycle.
- **Stall/ack gating:** at pc=8, stall=1 for 3 cycles → imem_req=0 and pc=8 held. Then ack=0 for 2 cycles with stall=0 → req=1, pc=8 held, instr_valid=0.
- **Redirects:**
  - branch_taken=1, branch_target=7'h20 with ack → pc=0x20.
  - jump=1 with jump_target=7'h40 and branch_taken=1 at once → pc=0x40.
  - jump without ack → ignored.
- **Wrap and misalignment:**
  - pc=7'h7C with ack → pc=0x00.
  - jump_target=7'h41 → pc = prior pc + 4 and align_err=1, still 1 ten cycles later.
- **Halt:** halt=1 with ack at pc=0x10 → halted=1, pc=0x10 frozen, imem_req=0 despite ack/jump activity. A subsequent rst=0 → pc=0, halted=0, align_err=0.
- **Mid-operation reset:** rst=0 in the same cycle as ack+jump → pc=RESET_PC, state BOOT, jump ignored.
